bin_to_bcd_seq: RTL and testbench



---
 rtl/bin_to_bcd_seq.sv | 156 +++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-packed-BCD converter.
// Ports: clk/reset (sync, active-high), start + bin_in (request, sampled in IDLE),
//        busy/done handshake, bcd_out (digit k at [4k+3:4k], held), ovf.
// Latency: done and bcd_out land BIN_W+1 cycles after the start edge.
// Throughput: one conversion per BIN_W+2 cycles. A start seen while busy is dropped.
// Optional build macro BCD_OVF_SAT_EN: out-of-range inputs saturate to all 9s and set ovf.
// Without the macro, bcd_out = bin_in mod 10^DIGITS and ovf is tied low.
module bin_to_bcd_seq #(
   parameter int BIN_W  = 20,
   parameter int DIGITS = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  ovf
);

   localparam int BCD_W = 4 * DIGITS;
   // Counter must still be at least one bit wide when BIN_W=1.
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [BIN_W-1:0]     bin_sr;
   logic [BCD_W-1:0]     scratch;
   logic [BCD_W-1:0]     scratch_adj;
   logic [BCD_W-1:0]     scratch_nxt;
   logic [CNT_W-1:0]     cnt;
   logic                 last_shift;

   assign last_shift = (cnt == CNT_LAST);

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state and handshake outputs
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_shift) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Add-3 correction on every digit in parallel, then shift the next binary
   // bit into the ones digit. Bit BCD_W-1 of the corrected value is the carry
   // that falls off the top digit.
   always_comb begin
      scratch_adj = scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) begin
            scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
         end
      end
      scratch_nxt = (scratch_adj << 1) | BCD_W'(bin_sr[BIN_W-1]);
   end

`ifdef BCD_OVF_SAT_EN
   logic ovf_trk;
   logic ovf_final;

   // A carry out of the top digit at any step means the input exceeds 10^DIGITS-1.
   assign ovf_final = ovf_trk | scratch_adj[BCD_W-1];
`else
   assign ovf = 1'b0;
`endif

   // Datapath: shift registers, bit counter and the held result
   always_ff @(posedge clk) begin
      if (reset) begin
         bin_sr  <= '0;
         scratch <= '0;
         cnt     <= '0;
         bcd_out <= '0;
`ifdef BCD_OVF_SAT_EN
         ovf_trk <= 1'b0;
         ovf     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  bin_sr  <= bin_in;
                  scratch <= '0;
                  cnt     <= '0;
`ifdef BCD_OVF_SAT_EN
                  ovf_trk <= 1'b0;
`endif
               end
            end
            SHIFT: begin
               bin_sr  <= bin_sr << 1;
               scratch <= scratch_nxt;
               cnt     <= cnt + CNT_W'(1);
`ifdef BCD_OVF_SAT_EN
               ovf_trk <= ovf_final;
`endif
               // Result is registered on the last shift so it is already
               // visible during the DONE cycle.
               if (last_shift) begin
`ifdef BCD_OVF_SAT_EN
                  if (ovf_final) begin
                     bcd_out <= {DIGITS{4'h9}};
                     ovf     <= 1'b1;
                  end else begin
                     bcd_out <= scratch_nxt;
                     ovf     <= 1'b0;
                  end
`else
                  bcd_out <= scratch_nxt;
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: self-checking bench for bin_to_bcd_seq.
// Drives a BIN_W=20/DIGITS=6 instance and a BIN_W=4/DIGITS=2 instance.
// Results are checked against an arithmetic (divide/modulo) BCD reference.
module tb_bin_to_bcd_seq;

   localparam int BIN_W    = 20;
   localparam int DIGITS   = 6;
   localparam int S_BIN_W  = 4;
   localparam int S_DIGITS = 2;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  start = 1'b0;
   logic [BIN_W-1:0]      bin_in = '0;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  ovf;

   logic                  s_start = 1'b0;
   logic [S_BIN_W-1:0]    s_bin_in = '0;
   logic                  s_busy;
   logic                  s_done;
   logic [4*S_DIGITS-1:0] s_bcd_out;
   logic                  s_ovf;

   int n_chk  = 0;
   int n_fail = 0;

   bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_dut (
      .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
      .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf)
   );

   bin_to_bcd_seq #(.BIN_W(S_BIN_W), .DIGITS(S_DIGITS)) u_dut_s (
      .clk(clk), .reset(reset), .start(s_start), .bin_in(s_bin_in),
      .busy(s_busy), .done(s_done), .bcd_out(s_bcd_out), .ovf(s_ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: decimal digits by repeated divide-by-ten.
   function automatic logic [63:0] ref_bcd(input longint v, input int digits);
      longint lim = 1;
      longint x = v;
      logic [63:0] r = '0;
      for (int i = 0; i < digits; i++) lim = lim * 10;
`ifdef BCD_OVF_SAT_EN
      if (x >= lim) begin
         for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'h9;
         return r;
      end
`endif
      x = x % lim;
      for (int i = 0; i < digits; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic ref_ovf(input longint v, input int digits);
      longint lim = 1;
      for (int i = 0; i < digits; i++) lim = lim * 10;
`ifdef BCD_OVF_SAT_EN
      return (v >= lim);
`else
      return 1'b0;
`endif
   endfunction

   task automatic wait_idle();
      int k = 0;
      @(negedge clk);
      while (busy && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("idle_timeout", busy, 0);
   endtask

   task automatic conv_and_check(input logic [BIN_W-1:0] v);
      logic [4*DIGITS-1:0] prev;
      int lat = 0;
      int bcnt = 0;
      bit held = 1'b1;
      wait_idle();
      start  = 1'b1;
      bin_in = v;
      prev   = bcd_out;
      @(posedge clk); #1;
      start  = 1'b0;
      bin_in = BIN_W'($urandom);
      for (int i = 1; i <= 60; i++) begin
         if (busy) bcnt++;
         if (done) begin
            lat = i;
            break;
         end
         if (bcd_out !== prev) held = 1'b0;
         @(posedge clk); #1;
      end
      check($sformatf("bcd(%0d)", v), bcd_out, ref_bcd(v, DIGITS));
      check($sformatf("ovf(%0d)", v), ovf, ref_ovf(v, DIGITS));
      check($sformatf("latency(%0d)", v), lat, BIN_W + 1);
      check($sformatf("busy_cycles(%0d)", v), bcnt, BIN_W + 1);
      check($sformatf("no_intermediate(%0d)", v), held, 1);
      @(posedge clk); #1;
      check($sformatf("done_one_cycle(%0d)", v), done, 0);
      check($sformatf("idle_after(%0d)", v), busy, 0);
   endtask

   task automatic conv_and_check_s(input logic [S_BIN_W-1:0] v);
      int lat = 0;
      @(negedge clk);
      s_start  = 1'b1;
      s_bin_in = v;
      @(posedge clk); #1;
      s_start  = 1'b0;
      s_bin_in = S_BIN_W'($urandom);
      for (int i = 1; i <= 20; i++) begin
         if (s_done) begin
            lat = i;
            break;
         end
         @(posedge clk); #1;
      end
      check($sformatf("s_bcd(%0d)", v), s_bcd_out, ref_bcd(v, S_DIGITS));
      check($sformatf("s_ovf(%0d)", v), s_ovf, ref_ovf(v, S_DIGITS));
      check($sformatf("s_latency(%0d)", v), lat, S_BIN_W + 1);
      @(posedge clk); #1;
      check($sformatf("s_idle_after(%0d)", v), s_busy, 0);
   endtask

   initial begin
      int n_done;
      int times [3];
      bit late_busy;
      bit saw_done;
      logic [63:0] got;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_bcd", bcd_out, 0);
      check("rst_ovf", ovf, 0);
      check("rst_s_busy", s_busy, 0);

      // Directed values, including the range edge and overflow case
      conv_and_check(20'd0);
      conv_and_check(20'd123456);
      conv_and_check(20'd999999);
      conv_and_check(20'd1048575);
      conv_and_check(20'd42);
      for (int i = 0; i < 20; i++) begin
         conv_and_check(BIN_W'($urandom_range(0, (1 << BIN_W) - 1)));
      end

      // Starts during SHIFT and during DONE must be dropped
      wait_idle();
      start  = 1'b1;
      bin_in = 20'd500;
      @(posedge clk); #1;
      start  = 1'b0;
      n_done = 0;
      late_busy = 1'b0;
      got = '0;
      for (int c = 1; c <= 50; c++) begin
         if (done) begin
            n_done++;
            got = 64'(bcd_out);
         end
         if (c >= BIN_W + 2 && busy) late_busy = 1'b1;
         start  = (c == 2 || c == BIN_W + 1);
         bin_in = 20'd777;
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("ign_done_count", n_done, 1);
      check("ign_bcd", got, ref_bcd(500, DIGITS));
      check("ign_no_restart", late_busy, 0);

      // Reset in the middle of a conversion
      wait_idle();
      start  = 1'b1;
      bin_in = 20'd654321;
      @(posedge clk); #1;
      start = 1'b0;
      saw_done = 1'b0;
      for (int c = 1; c < 10; c++) begin
         if (done) saw_done = 1'b1;
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midrst_bcd", bcd_out, 0);
      check("midrst_busy", busy, 0);
      check("midrst_ovf", ovf, 0);
      for (int c = 0; c < 30; c++) begin
         if (done || busy) saw_done = 1'b1;
         @(posedge clk); #1;
      end
      check("midrst_no_done", saw_done, 0);
      conv_and_check(20'd7);

      // start held high: back-to-back conversions
      wait_idle();
      start  = 1'b1;
      bin_in = 20'd314159;
      n_done = 0;
      times  = '{0, 0, 0};
      for (int c = 0; c < 120 && n_done < 3; c++) begin
         @(posedge clk); #1;
         if (done) begin
            times[n_done] = c;
            n_done++;
            check("b2b_bcd", bcd_out, ref_bcd(314159, DIGITS));
         end
      end
      start = 1'b0;
      check("b2b_gap1", times[1] - times[0], BIN_W + 2);
      check("b2b_gap2", times[2] - times[1], BIN_W + 2);

      // Small instance: full input sweep
      for (int v = 0; v < (1 << S_BIN_W); v++) begin
         conv_and_check_s(S_BIN_W'(v));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
